// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and sizing helpers for the pulse stretcher.
//   state_t   - window FSM states (IDLE, HIGH, GAP)
//   cnt_width - bit width for a down counter that must hold max(a,b)-1
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The counter is loaded with N-1, so $clog2(N) bits suffice.
    // Clamp to 1 bit so a 1-cycle window/gap still yields a legal vector.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down counter with zero flag.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears count)
//   load      - load load_val this cycle (wins over en)
//   load_val  - value to load
//   en        - decrement by one when nonzero
//   cnt       - current count
//   zero      - high when cnt == 0
module load_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event pulses into visible windows of
// HIGH_CYC high cycles followed by GAP_CYC low cycles. Pulses that arrive
// while a window/gap is running are queued in a saturating pending counter.
// Ports:
//   clk       - system clock
//   rst       - synchronous reset, active-high
//   pulse_in  - one event per high cycle
//   clr_ovf   - clears the overflow sticky flag
//   level     - stretched output, high while in HIGH
//   busy      - high whenever not IDLE
//   pend_cnt  - queued windows not yet started
//   overflow  - sticky, set when a pulse is dropped
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int HIGH_CYC = 1_000_000,
    parameter int GAP_CYC  = 500_000,
    parameter int MAX_PEND = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pulse_in,
    input  logic                          clr_ovf,
    output logic                          level,
    output logic                          busy,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
    output logic                          overflow
);

    localparam int CW = cnt_width(HIGH_CYC, GAP_CYC);
    localparam int PW = $clog2(MAX_PEND + 1);

    localparam logic [CW-1:0] HIGH_LD  = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

    state_t        state, state_nxt;
    logic          tmr_load;
    logic [CW-1:0] tmr_ld_val;
    logic          tmr_en;
    logic [CW-1:0] tmr_cnt;
    logic          tmr_zero;
    logic          gap_last;
    logic [PW-1:0] pend_nxt;
    logic          drop;

    load_down_counter #(.W(CW)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // Final cycle of the gap: this is where a queued (or coincident) pulse
    // launches the next window with no idle cycle in between.
    assign gap_last = (state == GAP) && tmr_zero;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_ld_val = HIGH_LD;
        tmr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_nxt = HIGH;
                    tmr_load  = 1'b1;
                end
            end
            HIGH: begin
                if (tmr_zero) begin
                    state_nxt  = GAP;
                    tmr_load   = 1'b1;
                    tmr_ld_val = GAP_LD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    if ((pend_cnt != '0) || pulse_in) begin
                        state_nxt = HIGH;
                        tmr_load  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending queue. On the last gap cycle a queued pulse is consumed; a
    // coincident new pulse either replaces it (net 0) or, with an empty
    // queue, is consumed directly. Everywhere else while busy, a pulse
    // queues or, if the queue is full, is dropped.
    always_comb begin
        pend_nxt = pend_cnt;
        drop     = 1'b0;
        if (state != IDLE) begin
            if (gap_last) begin
                if ((pend_cnt != '0) && !pulse_in)
                    pend_nxt = pend_cnt - PW'(1);
            end else if (pulse_in) begin
                if (pend_cnt < PEND_MAX)
                    pend_nxt = pend_cnt + PW'(1);
                else
                    drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign level = (state == HIGH);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HIGH_CYC=3, GAP_CYC=2, MAX_PEND=2.
// Each scenario starts from reset; cycle 0 is the first cycle after reset is
// released. Stimulus and expected outputs are per-cycle bitmasks.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       level;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    pulse_stretcher #(.HIGH_CYC(3), .GAP_CYC(2), .MAX_PEND(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .clr_ovf  (clr_ovf),
        .level    (level),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bt(input int n);
        logic [63:0] m;
        m = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pend expectation is {p1[c], p0[c]}.
    task automatic scn(input string name, input int ncyc,
                       input logic [63:0] pul, input logic [63:0] clr, input logic [63:0] rs,
                       input logic [63:0] lvl, input logic [63:0] bsy,
                       input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] ovf);
        rst = 1'b1; pulse_in = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            chk({name, ".level"},    c, 8'(level),    8'(lvl[c]));
            chk({name, ".busy"},     c, 8'(busy),     8'(bsy[c]));
            chk({name, ".pend_cnt"}, c, 8'(pend_cnt), 8'({p1[c], p0[c]}));
            chk({name, ".overflow"}, c, 8'(overflow), 8'(ovf[c]));
            pulse_in = pul[c];
            clr_ovf  = clr[c];
            rst      = rs[c];
            tick();
        end
        pulse_in = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
    endtask

    initial begin
        // Reset state while rst held, before any scenario.
        tick();
        chk("reset.level",    0, 8'(level),    8'd0);
        chk("reset.busy",     0, 8'(busy),     8'd0);
        chk("reset.pend_cnt", 0, 8'(pend_cnt), 8'd0);
        chk("reset.overflow", 0, 8'(overflow), 8'd0);

        // Single pulse: window 11-13, gap 14-15, idle from 16.
        scn("single", 24, bt(10), '0, '0,
            rng(11, 13), rng(11, 15), '0, '0, '0);

        // Three back-to-back pulses: windows 11-13, 16-18, 21-23.
        scn("queue3", 32, rng(10, 12), '0, '0,
            rng(11, 13) | rng(16, 18) | rng(21, 23), rng(11, 25),
            bt(12) | rng(16, 20), rng(13, 15), '0);

        // Overflow: drop at 13, clr at 30; later drop at 38, then drop+clr at 39,
        // clr alone at 41.
        scn("ovf", 56, rng(10, 13) | rng(35, 39), bt(30) | bt(39) | bt(41), '0,
            rng(11, 13) | rng(16, 18) | rng(21, 23) | rng(36, 38) | rng(41, 43) | rng(46, 48),
            rng(11, 25) | rng(36, 50),
            bt(12) | rng(16, 20) | bt(37) | rng(41, 45),
            rng(13, 15) | rng(38, 40),
            rng(14, 30) | rng(39, 41));

        // Pulse on the last gap cycle with an empty queue is consumed directly.
        scn("gaplast", 28, bt(10) | bt(15), '0, '0,
            rng(11, 13) | rng(16, 18), rng(11, 20), '0, '0, '0);

        // Reset mid-window together with a pulse: everything cleared at 13.
        scn("midrst", 28, rng(10, 12), '0, bt(12),
            rng(11, 12), rng(11, 12), bt(12), '0, '0);

        // Queued pulse plus a pulse on the last gap cycle: pend holds at 1.
        scn("netzero", 32, bt(10) | bt(12) | bt(15), '0, '0,
            rng(11, 13) | rng(16, 18) | rng(21, 23), rng(11, 25),
            rng(13, 20), '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
